// File: rtl/decode_stage_p_pkg.sv
// Shared types for the decode stage: control bundle, ALU/immediate
// selectors and the major opcode values.
package decode_stage_p_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_t;

  typedef enum logic [1:0] {
    IMM_DP  = 2'b00,
    IMM_MEM = 2'b01,
    IMM_BR  = 2'b10,
    IMM_RSV = 2'b11
  } imm_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       pcsrc;
    alu_t       alucontrol;
    logic [1:0] flagwrite;
    imm_t       immsrc;
    logic [1:0] regsrc;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_p_regfile_wt.sv
// Register file with write-through reads; the top index reads as
// PC+8 and is never written.
module regfile_wt #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 16,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] pc8
);

  localparam logic [AW-1:0] PC = AW'(NREGS - 1);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (we && wa != PC) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == PC)          ? pc8 :
               (we && wa == ra1)    ? wd  : mem[ra1];
  assign rd2 = (ra2 == PC)          ? pc8 :
               (we && wa == ra2)    ? wd  : mem[ra2];

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: control decode, immediate extension, load-use
// interlock and the D/E pipeline register.
module decode_stage_p
  import decode_stage_p_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       InstD,
  input  logic              ValidD,
  input  logic [DATA_W-1:0] PCPlus8,
  input  logic [3:0]        InFlags,
  input  logic              RegWriteW,
  input  logic [AW-1:0]     WA3W,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              FlushE,
  output logic              StallD,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [AW-1:0]     WA3E,
  output logic [AW-1:0]     RA1E,
  output logic [AW-1:0]     RA2E,
  output logic [AW-1:0]     RA1D,
  output logic [AW-1:0]     RA2D,
  output logic              ValidE,
  output logic              PCSrcE,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ALUControlE,
  output logic [1:0]        FlagWriteE,
  output logic [3:0]        CondE,
  output logic [3:0]        FlagsE
);

  logic [1:0]        op;
  logic [5:0]        funct;
  logic [3:0]        rd;
  ctrl_t             c;
  ctrl_t             ce;
  logic              ra2used;
  logic [DATA_W-1:0] extimm;
  logic [DATA_W-1:0] rd1d;
  logic [DATA_W-1:0] rd2d;

  assign op    = InstD[27:26];
  assign funct = InstD[25:20];
  assign rd    = InstD[15:12];

  always_comb begin
    c = '0;
    unique case (1'b1)
      op == OP_DP: begin
        c.alusrc   = funct[5];
        c.regwrite = 1'b1;
        unique case (funct[4:1])
          4'b0100: c.alucontrol = ALU_ADD;
          4'b0010: c.alucontrol = ALU_SUB;
          4'b0000: c.alucontrol = ALU_AND;
          4'b1100: c.alucontrol = ALU_ORR;
          4'b1010: begin
            c.alucontrol = ALU_SUB;
            c.regwrite   = 1'b0;
          end
          default: c.alucontrol = ALU_ADD;
        endcase
        c.flagwrite = {funct[0], funct[0] &
          (c.alucontrol == ALU_ADD ||
           c.alucontrol == ALU_SUB)};
        c.immsrc = IMM_DP;
      end
      op == OP_MEM: begin
        c.alusrc     = 1'b1;
        c.alucontrol = ALU_ADD;
        c.immsrc     = IMM_MEM;
        if (funct[0]) begin
          c.regwrite = 1'b1;
          c.memtoreg = 1'b1;
        end else begin
          c.memwrite  = 1'b1;
          c.regsrc[1] = 1'b1;
        end
      end
      op == OP_B: begin
        c.branch     = 1'b1;
        c.alusrc     = 1'b1;
        c.immsrc     = IMM_BR;
        c.regsrc[0]  = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      default: ;
    endcase
    c.pcsrc = (c.regwrite & (rd == 4'(NREGS - 1))) | c.branch;
  end

  assign RA1D = c.regsrc[0] ? AW'(NREGS - 1) : AW'(InstD[19:16]);
  assign RA2D = c.regsrc[1] ? AW'(InstD[15:12]) : AW'(InstD[3:0]);

  // Rm is not an operand for DP-immediate forms or branches.
  assign ra2used = !((op == OP_DP && c.alusrc) || op == OP_B);

  always_comb begin
    unique case (c.immsrc)
      IMM_MEM: extimm = DATA_W'(InstD[11:0]);
      IMM_BR:  extimm = DATA_W'($signed({InstD[23:0], 2'b00}));
      default: extimm = DATA_W'(InstD[7:0]);
    endcase
  end

  regfile_wt #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (RA1D),
    .ra2   (RA2D),
    .rd1   (rd1d),
    .rd2   (rd2d),
    .we    (RegWriteW),
    .wa    (WA3W),
    .wd    (ResultW),
    .pc8   (PCPlus8)
  );

  assign StallD = ValidE & MemtoRegE & ValidD &
    ((RA1D == WA3E) | ((RA2D == WA3E) & ra2used));

  assign ce = ValidD ? c : '0;

  always_ff @(posedge clk) begin
    if (reset || FlushE || StallD) begin
      ValidE      <= 1'b0;
      PCSrcE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= '0;
      FlagWriteE  <= '0;
      CondE       <= '0;
      FlagsE      <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ExtImmE     <= '0;
      WA3E        <= '0;
      RA1E        <= '0;
      RA2E        <= '0;
    end else begin
      ValidE      <= ValidD;
      PCSrcE      <= ce.pcsrc;
      RegWriteE   <= ce.regwrite;
      MemtoRegE   <= ce.memtoreg;
      MemWriteE   <= ce.memwrite;
      BranchE     <= ce.branch;
      ALUSrcE     <= ce.alusrc;
      ALUControlE <= ce.alucontrol;
      FlagWriteE  <= ce.flagwrite;
      CondE       <= InstD[31:28];
      FlagsE      <= InFlags;
      RD1E        <= rd1d;
      RD2E        <= rd2d;
      ExtImmE     <= extimm;
      WA3E        <= AW'(rd);
      RA1E        <= RA1D;
      RA2E        <= RA2D;
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed and random checks of decode_stage_p against a reference
// model of the decode rules, register file and D/E register.
module tb_decode_stage_p;

  logic        clk = 0;
  logic        reset;
  logic [31:0] InstD;
  logic        ValidD;
  logic [31:0] PCPlus8;
  logic [3:0]  InFlags;
  logic        RegWriteW;
  logic [3:0]  WA3W;
  logic [31:0] ResultW;
  logic        FlushE;
  logic        StallD;
  logic [31:0] RD1E, RD2E, ExtImmE;
  logic [3:0]  WA3E, RA1E, RA2E, RA1D, RA2D;
  logic        ValidE, PCSrcE, RegWriteE, MemtoRegE;
  logic        MemWriteE, BranchE, ALUSrcE;
  logic [1:0]  ALUControlE, FlagWriteE;
  logic [3:0]  CondE, FlagsE;

  logic        reset8;
  logic [31:0] InstD8;
  logic        ValidD8;
  logic [15:0] PCPlus8_8;
  logic [3:0]  InFlags8;
  logic        RegWriteW8;
  logic [2:0]  WA3W8;
  logic [15:0] ResultW8;
  logic        FlushE8;
  logic        StallD8;
  logic [15:0] RD1E8, RD2E8, ExtImmE8;
  logic [2:0]  WA3E8, RA1E8, RA2E8, RA1D8, RA2D8;
  logic        ValidE8, PCSrcE8, RegWriteE8, MemtoRegE8;
  logic        MemWriteE8, BranchE8, ALUSrcE8;
  logic [1:0]  ALUControlE8, FlagWriteE8;
  logic [3:0]  CondE8, FlagsE8;

  always #5 clk = ~clk;

  decode_stage_p dut (
    .clk(clk), .reset(reset), .InstD(InstD), .ValidD(ValidD),
    .PCPlus8(PCPlus8), .InFlags(InFlags), .RegWriteW(RegWriteW),
    .WA3W(WA3W), .ResultW(ResultW), .FlushE(FlushE),
    .StallD(StallD), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E), .RA1D(RA1D),
    .RA2D(RA2D), .ValidE(ValidE), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE),
    .CondE(CondE), .FlagsE(FlagsE)
  );

  decode_stage_p #(.DATA_W(16), .NREGS(8)) dut8 (
    .clk(clk), .reset(reset8), .InstD(InstD8), .ValidD(ValidD8),
    .PCPlus8(PCPlus8_8), .InFlags(InFlags8),
    .RegWriteW(RegWriteW8), .WA3W(WA3W8), .ResultW(ResultW8),
    .FlushE(FlushE8), .StallD(StallD8), .RD1E(RD1E8),
    .RD2E(RD2E8), .ExtImmE(ExtImmE8), .WA3E(WA3E8),
    .RA1E(RA1E8), .RA2E(RA2E8), .RA1D(RA1D8), .RA2D(RA2D8),
    .ValidE(ValidE8), .PCSrcE(PCSrcE8), .RegWriteE(RegWriteE8),
    .MemtoRegE(MemtoRegE8), .MemWriteE(MemWriteE8),
    .BranchE(BranchE8), .ALUSrcE(ALUSrcE8),
    .ALUControlE(ALUControlE8), .FlagWriteE(FlagWriteE8),
    .CondE(CondE8), .FlagsE(FlagsE8)
  );

  typedef struct packed {
    logic v, pcs, rw, m2r, mw, br, as;
    logic [1:0]  alu, fw;
    logic [3:0]  cond, flags, wa3, ra1, ra2;
    logic [31:0] rd1, rd2, imm;
  } e_t;

  typedef struct packed {
    logic rw, m2r, mw, br, as, pcs, ra2used;
    logic [1:0]  alu, fw;
    logic [3:0]  ra1, ra2;
    logic [31:0] imm;
  } dec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] rf [16];
  e_t          me;
  logic        st_seen;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    logic [5:0] f;
    f = i[25:20];
    d = '0;
    d.ra1 = i[19:16];
    d.ra2 = i[3:0];
    d.ra2used = 1'b1;
    d.imm = {24'd0, i[7:0]};
    if (i[27:26] == 2'd0) begin
      d.as = f[5];
      d.ra2used = !f[5];
      if (f[4:1] == 4'd2 || f[4:1] == 4'd10) d.alu = 2'd1;
      else if (f[4:1] == 4'd0) d.alu = 2'd2;
      else if (f[4:1] == 4'd12) d.alu = 2'd3;
      d.rw = (f[4:1] != 4'd10);
      d.fw = {f[0], f[0] && d.alu < 2};
    end else if (i[27:26] == 2'd1) begin
      d.as = 1;
      d.imm = {20'd0, i[11:0]};
      if (f[0]) begin
        d.rw = 1; d.m2r = 1;
      end else begin
        d.mw = 1; d.ra2 = i[15:12];
      end
    end else if (i[27:26] == 2'd2) begin
      d.br = 1; d.as = 1; d.ra1 = 4'd15; d.ra2used = 0;
      d.imm = {{6{i[23]}}, i[23:0], 2'b00};
    end
    d.pcs = (d.rw && i[15:12] == 4'd15) || d.br;
    return d;
  endfunction

  function automatic logic [31:0] rdv(input logic [3:0] a);
    if (a == 4'd15) return PCPlus8;
    if (RegWriteW && WA3W == a) return ResultW;
    return rf[a];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_e(input e_t x);
    check("ValidE", ValidE, x.v);
    check("PCSrcE", PCSrcE, x.pcs);
    check("RegWriteE", RegWriteE, x.rw);
    check("MemtoRegE", MemtoRegE, x.m2r);
    check("MemWriteE", MemWriteE, x.mw);
    check("BranchE", BranchE, x.br);
    check("ALUSrcE", ALUSrcE, x.as);
    check("ALUControlE", ALUControlE, x.alu);
    check("FlagWriteE", FlagWriteE, x.fw);
    check("CondE", CondE, x.cond);
    check("FlagsE", FlagsE, x.flags);
    check("WA3E", WA3E, x.wa3);
    check("RA1E", RA1E, x.ra1);
    check("RA2E", RA2E, x.ra2);
    check("RD1E", RD1E, x.rd1);
    check("RD2E", RD2E, x.rd2);
    check("ExtImmE", ExtImmE, x.imm);
  endtask

  task automatic cycle(input logic [31:0] inst, input logic vd,
                       input logic rww, input logic [3:0] wa,
                       input logic [31:0] res, input logic fl);
    dec_t d;
    e_t   ne;
    logic st;
    InstD = inst; ValidD = vd; RegWriteW = rww;
    WA3W = wa; ResultW = res; FlushE = fl;
    #1;
    d = ref_dec(inst);
    st = me.v && me.m2r && vd &&
         (d.ra1 == me.wa3 || (d.ra2 == me.wa3 && d.ra2used));
    st_seen = StallD;
    check("StallD", StallD, st);
    check("RA1D", RA1D, d.ra1);
    check("RA2D", RA2D, d.ra2);
    ne = '0;
    if (!(reset || fl || st)) begin
      ne.v = vd;
      if (vd) begin
        ne.pcs = d.pcs; ne.rw = d.rw; ne.m2r = d.m2r;
        ne.mw = d.mw; ne.br = d.br; ne.as = d.as;
        ne.alu = d.alu; ne.fw = d.fw;
      end
      ne.cond = inst[31:28]; ne.flags = InFlags;
      ne.wa3 = inst[15:12]; ne.ra1 = d.ra1; ne.ra2 = d.ra2;
      ne.rd1 = rdv(d.ra1); ne.rd2 = rdv(d.ra2); ne.imm = d.imm;
    end
    tick();
    check_e(ne);
    if (reset) begin
      for (int k = 0; k < 16; k++) rf[k] = '0;
    end else if (rww && wa != 4'd15) begin
      rf[wa] = res;
    end
    me = ne;
  endtask

  function automatic logic [3:0] rsel();
    return ($urandom_range(0, 7) == 0) ? 4'd15
                                       : 4'($urandom_range(0, 5));
  endfunction

  initial begin
    logic [31:0] ri;
    reset = 1; InstD = 0; ValidD = 0; PCPlus8 = 32'h108;
    InFlags = 0; RegWriteW = 0; WA3W = 0; ResultW = 0; FlushE = 0;
    reset8 = 1; InstD8 = 0; ValidD8 = 0; PCPlus8_8 = 0;
    InFlags8 = 0; RegWriteW8 = 0; WA3W8 = 0; ResultW8 = 0;
    FlushE8 = 0;
    me = '0;
    for (int k = 0; k < 16; k++) rf[k] = '0;
    tick();
    cycle(32'h0, 0, 0, 0, 0, 0);
    check("reset_valid", ValidE, 1'b0);
    reset = 0;

    cycle(32'h0, 0, 1, 4'd3, 32'h11, 0);
    cycle(32'hE0831003, 1, 0, 0, 0, 0);
    check("add_rd1", RD1E, 32'h11);
    check("add_rd2", RD2E, 32'h11);
    check("add_rw", RegWriteE, 1'b1);
    check("add_alu", ALUControlE, 2'b00);

    cycle(32'hE0820000, 1, 1, 4'd2, 32'hAB, 0);
    check("wt_rd1", RD1E, 32'hAB);

    cycle(32'hE5904000, 1, 0, 0, 0, 0);
    cycle(32'hE2845001, 1, 0, 0, 0, 0);
    check("lu_stall", st_seen, 1'b1);
    check("lu_bubble", ValidE, 1'b0);
    cycle(32'hE2845001, 1, 0, 0, 0, 0);
    check("lu_nostall", st_seen, 1'b0);
    check("lu_issue", ValidE, 1'b1);

    cycle(32'hEAFFFFFE, 1, 0, 0, 0, 0);
    check("b_imm", ExtImmE, 32'hFFFFFFF8);
    check("b_br", BranchE, 1'b1);
    check("b_pcs", PCSrcE, 1'b1);
    check("b_ra1", RA1E, 4'd15);
    check("b_rd1", RD1E, PCPlus8);

    cycle(32'hE0831003, 1, 0, 0, 0, 1);
    check("fl_valid", ValidE, 1'b0);
    check("fl_rw", RegWriteE, 1'b0);
    cycle(32'hE5904000, 1, 0, 0, 0, 0);
    cycle(32'hE2845001, 1, 0, 0, 0, 1);
    check("flst_stall", st_seen, 1'b1);
    check("flst_valid", ValidE, 1'b0);

    cycle(32'hE5904000, 1, 0, 0, 0, 0);
    reset = 1;
    cycle(32'hE2845001, 1, 0, 0, 0, 0);
    check("rst_stall_seen", st_seen, 1'b1);
    check("rst_stall_clr", StallD, 1'b0);
    reset = 0;

    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      ri[19:16] = rsel(); ri[15:12] = rsel(); ri[3:0] = rsel();
      PCPlus8 = $urandom;
      InFlags = 4'($urandom);
      cycle(ri, $urandom_range(0, 7) != 0, 1'($urandom),
            rsel(), $urandom, $urandom_range(0, 9) == 0);
    end

    tick();
    reset8 = 0;
    InstD8 = 32'hEAFFFFFE; ValidD8 = 1; PCPlus8_8 = 16'h1234;
    RegWriteW8 = 1; WA3W8 = 3'd7; ResultW8 = 16'h5555;
    #1;
    check("n8_ra1d", RA1D8, 3'd7);
    tick();
    check("n8_rd1", RD1E8, 16'h1234);
    check("n8_imm", ExtImmE8, 16'hFFF8);
    check("n8_ra1e", RA1E8, 3'd7);
    ValidD8 = 0; InstD8 = 0; WA3W8 = 3'd2; ResultW8 = 16'h0BEE;
    tick();
    ValidD8 = 1; InstD8 = 32'hE0820000; RegWriteW8 = 0;
    tick();
    check("n8_rd2reg", RD1E8, 16'h0BEE);
    check("n8_valid", ValidE8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 SHALL have parameters, one per line:
 - DATA_W, default 32, datapath and register width.
 - NREGS, default 16, architectural register count; index NREGS-1 is PC.
 - AW, default $clog2(NREGS), register index width.
REQ-002 SHALL have ports, one per line, clock and reset first:
 - clk  in  1  single clock; all state updates on rising edge.
 - reset  in  1  synchronous, active-high.
 - InstD  in  32  fetched instruction.
 - ValidD  in  1  InstD holds a real instruction.
 - PCPlus8  in  DATA_W  value returned for reads of register NREGS-1.
 - InFlags  in  4  NZCV captured into the D/E register.
 - RegWriteW  in  1  writeback enable.
 - WA3W  in  AW  writeback index.
 - ResultW  in  DATA_W  writeback data.
 - FlushE  in  1  external flush of the D/E register (branch taken).
 - StallD  out  1  load-use interlock; fetch and decode hold.
 - RD1E, RD2E, ExtImmE  out  DATA_W  registered operands and immediate.
 - WA3E, RA1E, RA2E  out  AW  registered register indices.
 - RA1D, RA2D  out  AW  current decode read indices, for the hazard unit.
 - ValidE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE  out  1  registered control.
 - ALUControlE, FlagWriteE  out  2  registered control.
 - CondE, FlagsE  out  4  registered condition and flags.

Function
REQ-003 Field decode SHALL be: Op=InstD[27:26], Funct=InstD[25:20], Rd=InstD[15:12], Cond=InstD[31:28].
REQ-004 Op=00 (DP) SHALL decode as follows:
 - ALUSrc=Funct[5].
 - ALUControl: Funct[4:1] 0100->00, 0010->01, 0000->10, 1100->11, 1010 (CMP)->01.
 - RegWrite=1 except for CMP.
 - FlagWrite={Funct[0], Funct[0]&(ALUControl is 00 or 01)}.
 - ImmSrc=00.
REQ-005 Op=01 (MEM) SHALL decode as ALUSrc=1, ALUControl=00, ImmSrc=01. Funct[0]=1 (LDR): RegWrite=1, MemtoReg=1. Funct[0]=0 (STR): MemWrite=1, RegSrc[1]=1.
REQ-006 Op=10 (B) SHALL decode as Branch=1, ALUSrc=1, ImmSrc=10, RegSrc[0]=1, ALUControl=00. Op=11 SHALL decode all control to 0.
REQ-007 PCSrcD SHALL be (RegWrite & Rd==NREGS-1) | Branch.
REQ-008 RA1D SHALL be RegSrc[0] ? NREGS-1 : InstD[19:16]. RA2D SHALL be RegSrc[1] ? InstD[15:12] : InstD[3:0]. Indices SHALL be truncated to AW bits.
REQ-009 Immediate extension SHALL be:
 - ImmSrc 00: zero-extend InstD[7:0].
 - ImmSrc 01: zero-extend InstD[11:0].
 - ImmSrc 10: sign-extend {InstD[23:0],2'b00} to DATA_W.
REQ-010 Register reads SHALL be combinational. Reading index NREGS-1 SHALL return PCPlus8.
REQ-011 Write-through: if RegWriteW and WA3W equals the read index (not NREGS-1), the read SHALL return ResultW in the same cycle.
REQ-012 Writes SHALL occur on the rising edge when RegWriteW=1 and WA3W!=NREGS-1. Writes to NREGS-1 SHALL be ignored.
REQ-013 StallD SHALL be 1 when ValidE & MemtoRegE & ValidD & (RA1D==WA3E | (RA2D==WA3E & RA2 used)). RA2 is unused for DP immediate (ALUSrc=1, Op=00) and for B.
REQ-014 D/E register update priority per edge SHALL be:
 - reset: clear.
 - FlushE or StallD: clear, inserting a bubble with ValidE=0 and all control 0.
 - otherwise: load decode values, with ValidE=ValidD.
REQ-015 Every registered control output SHALL be gated by ValidD at load, so invalid instructions are never issued.
REQ-016 Decode-to-E latency SHALL be exactly 1 cycle. A stall SHALL last exactly 1 cycle per load-use pair.
REQ-017 When FlushE and StallD are asserted together, the flush SHALL take effect. StallD SHALL still be driven combinationally.

Reset
REQ-018 On reset, all D/E outputs SHALL be 0, including ValidE=0.
REQ-019 On reset, register file entries 0..NREGS-2 SHALL be 0.
REQ-020 Reset asserted mid-stall SHALL clear StallD on the next cycle, since it requires ValidE=1.

Structure
REQ-021 The shared package SHALL hold:
 - typedef ctrl_t: the control bundle of REQ-004..007.
 - enums for ALUControl and ImmSrc.
 - opcode constants OP_DP, OP_MEM, OP_B.
REQ-022 There SHALL be one sub-module, regfile_wt (parametrised DATA_W, NREGS), implementing REQ-010..012 and REQ-019. Decode, extension, interlock and the D/E register SHALL live in decode_stage_p.

Verification
REQ-023 Scenario: write R3=0x11 via W, then decode ADD R1,R3,R3 (0xE0831003) -> next cycle RD1E=RD2E=0x11, RegWriteE=1, ALUControlE=00.
REQ-024 Scenario: RegWriteW=1, WA3W=2, ResultW=0xAB in the same cycle as decoding a read of R2 -> RD1E=0xAB.
REQ-025 Scenario: LDR R4 in E (MemtoRegE=1, WA3E=4), then ADD R5,R4,#1 in D -> StallD=1 for 1 cycle, bubble with ValidE=0. ADD issues on the following cycle.
REQ-026 Scenario: B with offset 0xFFFFFE -> ExtImmE=0xFFFFFFF8, BranchE=1, PCSrcE=1, RA1E=15.
REQ-027 Scenario: FlushE=1 with a valid DP instruction in D -> all E control 0 and ValidE=0. Repeat with StallD=1 simultaneously -> same result.
REQ-028 Scenario: reset asserted during a stall -> next cycle all outputs 0 and StallD=0. Also run with DATA_W=16, NREGS=8 -> reading R7 returns PCPlus8.
